// File: rtl/split_scheduler.sv
// rtl/split_scheduler.sv - split-transaction table and round-robin resume scheduler
// Optional per-entry age timeout enabled by defining SPLIT_TIMEOUT_EN.
module split_scheduler #(
    parameter int NUM_SLAVES = 3,
    parameter int MID_W      = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SLAVES-1:0]         split_in,
    input  logic [MID_W-1:0]              cur_mid,
    input  logic [NUM_SLAVES-1:0]         ready_in,
    output logic                          split,
    output logic                          split_req,
    output logic [MID_W-1:0]              split_mid,
    output logic [$clog2(NUM_SLAVES)-1:0] split_sid,
    input  logic                          split_grant,
    output logic [NUM_SLAVES-1:0]         pending,
    output logic                          proto_err,
    output logic                          timeout_err,
    output logic [$clog2(NUM_SLAVES)-1:0] to_sid
);

    localparam int SID_W = $clog2(NUM_SLAVES);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("split_scheduler: TIMEOUT must be >= 2");
    end

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state, state_nxt;
    logic [NUM_SLAVES-1:0]   valid;
    logic [MID_W-1:0]        mid_tab [NUM_SLAVES];
    logic [SID_W-1:0]        rr_ptr, sid_q, pick_sid;
    logic [MID_W-1:0]        mid_q;
    logic [NUM_SLAVES-1:0]   locked, grant_clr, hit, tmo_hit, eligible, alloc;
    logic                    multi, proto, pick_found;

    always_comb begin
        locked = '0;
        if (state == REQ)
            locked[sid_q] = 1'b1;
    end

    assign grant_clr = locked & {NUM_SLAVES{split_grant}};
    // An entry being granted this cycle may be re-split without a protocol error.
    assign hit   = split_in & valid & ~grant_clr;
    assign multi = |(split_in & (split_in - NUM_SLAVES'(1)));
    assign proto = multi | (|hit);
    assign alloc = split_in & {NUM_SLAVES{~proto}};

`ifdef SPLIT_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    logic [AGE_W-1:0] age [NUM_SLAVES];
    logic [SID_W-1:0] tmo_sid;

    always_comb begin
        tmo_hit = '0;
        tmo_sid = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            tmo_hit[i] = valid[i] && !locked[i] && (age[i] == AGE_W'(TIMEOUT));
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (tmo_hit[i])
                tmo_sid = SID_W'(i);
    end
`else
    assign tmo_hit     = '0;
    assign timeout_err = 1'b0;
    assign to_sid      = '0;
`endif

    assign eligible = valid & ready_in & ~tmo_hit;

    // Search starts one past the last served slave and wraps.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_sid   = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_SLAVES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SLAVES)
                idx = idx - NUM_SLAVES;
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_sid   = SID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_found) state_nxt = REQ;
            REQ:  if (split_grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            rr_ptr    <= SID_W'(NUM_SLAVES - 1);
            sid_q     <= '0;
            mid_q     <= '0;
            split     <= 1'b0;
            proto_err <= 1'b0;
            for (int i = 0; i < NUM_SLAVES; i++)
                mid_tab[i] <= '0;
        end else begin
            state     <= state_nxt;
            split     <= |split_in;
            proto_err <= proto;
            if (state == IDLE && pick_found) begin
                sid_q <= pick_sid;
                mid_q <= mid_tab[pick_sid];
            end
            if (state == REQ && split_grant)
                rr_ptr <= sid_q;
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (grant_clr[i] || tmo_hit[i])
                    valid[i] <= 1'b0;
                if (alloc[i]) begin
                    valid[i]   <= 1'b1;
                    mid_tab[i] <= cur_mid;
                end
            end
        end
    end

`ifdef SPLIT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
            to_sid      <= '0;
            for (int i = 0; i < NUM_SLAVES; i++)
                age[i] <= '0;
        end else begin
            timeout_err <= |tmo_hit;
            if (|tmo_hit)
                to_sid <= tmo_sid;
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (alloc[i])
                    age[i] <= '0;
                else if (valid[i] && !ready_in[i] && !locked[i] && !tmo_hit[i])
                    age[i] <= age[i] + AGE_W'(1);
            end
        end
    end
`endif

    assign split_req = (state == REQ);
    assign split_mid = mid_q;
    assign split_sid = sid_q;
    assign pending   = valid;

endmodule
